// File: rtl/ittage_update_queue_if.sv
// Fetch/backend/predictor-facing bundle of the ITTAGE update queue.
// slave = queue side, master = driver (fetch, backend, predictor harness).
interface ittage_updq_if #(
    parameter int unsigned PLEN           = 32,
    parameter int unsigned ID_W           = 3,
    parameter int unsigned PATH_HIST_BITS = 16
);
    logic [PATH_HIST_BITS-1:0] predict_ctx_o;
    logic                      alloc_valid_i;
    logic [PLEN-1:0]           alloc_pc_i;
    logic [PLEN-1:0]           alloc_target_i;
    logic                      alloc_ready_o;
    logic [ID_W-1:0]           alloc_id_o;
    logic                      resolve_valid_i;
    logic [ID_W-1:0]           resolve_id_i;
    logic [PLEN-1:0]           resolve_target_i;
    logic                      resolve_mispred_i;
    logic                      flush_i;
    logic                      update_valid_o;
    logic [PLEN-1:0]           update_pc_o;
    logic [PATH_HIST_BITS-1:0] update_ctx_o;
    logic [PLEN-1:0]           update_target_o;
    logic [31:0]               perf_update_o;
    logic [31:0]               perf_mispred_o;

    modport slave (
        input  alloc_valid_i, alloc_pc_i, alloc_target_i,
        input  resolve_valid_i, resolve_id_i, resolve_target_i,
        input  resolve_mispred_i, flush_i,
        output predict_ctx_o, alloc_ready_o, alloc_id_o,
        output update_valid_o, update_pc_o, update_ctx_o,
        output update_target_o, perf_update_o, perf_mispred_o
    );

    modport master (
        output alloc_valid_i, alloc_pc_i, alloc_target_i,
        output resolve_valid_i, resolve_id_i, resolve_target_i,
        output resolve_mispred_i, flush_i,
        input  predict_ctx_o, alloc_ready_o, alloc_id_o,
        input  update_valid_o, update_pc_o, update_ctx_o,
        input  update_target_o, perf_update_o, perf_mispred_o
    );
endinterface

// File: rtl/ittage_update_queue.sv
// ITTAGE update queue: speculative path history and in-order update drain.
// Define ITTAGE_UPDQ_PERF_EN to build the update/mispredict perf counters.
module ittage_update_queue #(
    parameter int unsigned PLEN           = 32,
    parameter int unsigned ILEN           = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned PATH_HIST_BITS = 16,
    parameter int unsigned HIST_SHIFT     = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    ittage_updq_if.slave bus
);
    localparam int unsigned ID_W = $clog2(DEPTH);
    localparam int unsigned LSB  = $clog2(ILEN / 8);

    typedef logic [ID_W:0]           ptr_t;
    typedef logic [ID_W-1:0]         idx_t;
    typedef logic [PATH_HIST_BITS-1:0] hist_t;

    function automatic hist_t shift_hist(hist_t h, logic [PLEN-1:0] t);
        return {h[PATH_HIST_BITS-HIST_SHIFT-1:0], t[LSB+:HIST_SHIFT]};
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    ptr_t             head_q, head_d, tail_q, tail_d;
    hist_t            hist_q, hist_d;
    logic [PLEN-1:0]  pc_q  [DEPTH];
    logic [PLEN-1:0]  tgt_q [DEPTH];
    hist_t            ctx_q [DEPTH];

    logic             upd_valid_q;
    logic [PLEN-1:0]  upd_pc_q, upd_tgt_q;
    hist_t            upd_ctx_q;

    idx_t head_idx, tail_idx, rid, rid_off, last_idx;
    idx_t off [DEPTH];
    ptr_t keep;
    logic full, accept, drain, res_ok, mispred, run;
    logic unused_tgt;

    assign head_idx = head_q[ID_W-1:0];
    assign tail_idx = tail_q[ID_W-1:0];
    assign rid      = bus.resolve_id_i;
    assign rid_off  = rid - head_idx;
    assign full     = (head_idx == tail_idx) && (head_q[ID_W] != tail_q[ID_W]);
    assign drain    = valid_q[head_idx] && done_q[head_idx];
    assign res_ok   = bus.resolve_valid_i && valid_q[rid];
    assign mispred  = res_ok && bus.resolve_mispred_i;

    assign bus.alloc_ready_o = !full && !bus.flush_i &&
                               !(bus.resolve_valid_i && bus.resolve_mispred_i);
    assign accept            = bus.alloc_valid_i && bus.alloc_ready_o;
    assign bus.alloc_id_o    = tail_idx;
    assign bus.predict_ctx_o = hist_q;

    assign bus.update_valid_o  = upd_valid_q;
    assign bus.update_pc_o     = upd_pc_q;
    assign bus.update_ctx_o    = upd_ctx_q;
    assign bus.update_target_o = upd_tgt_q;

    assign unused_tgt = ^bus.alloc_target_i;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            off[k] = idx_t'(k) - head_idx;
        end
    end

    // Flush survivors: the run of resolved entries starting at head.
    always_comb begin
        keep = '0;
        run  = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            run = run && valid_q[head_idx + idx_t'(k)]
                      && done_q[head_idx + idx_t'(k)];
            if (run) keep = keep + ptr_t'(1);
        end
    end

    assign last_idx = head_idx + keep[ID_W-1:0] - idx_t'(1);

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        hist_d  = hist_q;
        if (drain) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + ptr_t'(1);
        end
        if (bus.flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ({1'b0, off[k]} >= keep) valid_d[k] = 1'b0;
            end
            tail_d = head_q + keep;
            if (keep != '0) hist_d = shift_hist(ctx_q[last_idx], tgt_q[last_idx]);
        end else begin
            if (res_ok) done_d[rid] = 1'b1;
            if (mispred) begin
                hist_d = shift_hist(ctx_q[rid], bus.resolve_target_i);
                tail_d = head_q + ptr_t'(rid_off) + ptr_t'(1);
                for (int k = 0; k < DEPTH; k++) begin
                    if (off[k] > rid_off) valid_d[k] = 1'b0;
                end
            end else if (accept) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                tail_d            = tail_q + ptr_t'(1);
                hist_d            = shift_hist(hist_q, bus.alloc_target_i);
            end
        end
    end

    // Payload is only ever read behind a valid bit, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pc_q[tail_idx]  <= bus.alloc_pc_i;
            ctx_q[tail_idx] <= hist_q;
        end
        if (res_ok && !bus.flush_i) tgt_q[rid] <= bus.resolve_target_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            hist_q      <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_ctx_q   <= '0;
            upd_tgt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            hist_q      <= hist_d;
            upd_valid_q <= drain;
            if (drain) begin
                upd_pc_q  <= pc_q[head_idx];
                upd_ctx_q <= ctx_q[head_idx];
                upd_tgt_q <= tgt_q[head_idx];
            end
        end
    end

`ifdef ITTAGE_UPDQ_PERF_EN
    logic [31:0] perf_upd_q, perf_mis_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            if (drain) perf_upd_q <= perf_upd_q + 32'd1;
            if (mispred) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign bus.perf_update_o  = perf_upd_q;
    assign bus.perf_mispred_o = perf_mis_q;
`else
    assign bus.perf_update_o  = '0;
    assign bus.perf_mispred_o = '0;
`endif
endmodule

// File: tb/tb_ittage_update_queue.sv
// Bench for ittage_update_queue: directed scenarios plus random traffic
// checked against a queue-of-records reference model.
module tb_ittage_update_queue;
    localparam int PLEN  = 32;
    localparam int DEPTH = 8;
    localparam int ID_W  = 3;
    localparam int HB    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ittage_updq_if #(.PLEN(PLEN), .ID_W(ID_W), .PATH_HIST_BITS(HB)) bus ();

    ittage_update_queue #(
        .PLEN(PLEN), .ILEN(32), .DEPTH(DEPTH),
        .PATH_HIST_BITS(HB), .HIST_SHIFT(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [15:0] ctx;
        bit          done;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          tail_id;
    logic [15:0] hist;
    logic        e_uv;
    logic [31:0] e_upc, e_utgt;
    logic [15:0] e_uctx;
    int          e_pupd, e_pmis;
    int          n_chk = 0;
    int          n_pass = 0;

    // 2 target bits (word-aligned, bits [3:2]) enter the history per jump.
    function automatic logic [15:0] shl(logic [15:0] h, logic [31:0] t);
        return 16'((h * 4) + ((t / 4) % 4));
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        tail_id = 0;
        hist    = '0;
        e_uv    = 1'b0;
        e_upc   = '0;
        e_uctx  = '0;
        e_utgt  = '0;
        e_pupd  = 0;
        e_pmis  = 0;
    endtask

    task automatic drive_idle();
        bus.alloc_valid_i     = 1'b0;
        bus.alloc_pc_i        = '0;
        bus.alloc_target_i    = '0;
        bus.resolve_valid_i   = 1'b0;
        bus.resolve_id_i      = '0;
        bus.resolve_target_i  = '0;
        bus.resolve_mispred_i = 1'b0;
        bus.flush_i           = 1'b0;
    endtask

    task automatic check_perf();
`ifdef ITTAGE_UPDQ_PERF_EN
        check("perf_update", bus.perf_update_o, e_pupd);
        check("perf_mispred", bus.perf_mispred_o, e_pmis);
`else
        check("perf_update", bus.perf_update_o, 0);
        check("perf_mispred", bus.perf_mispred_o, 0);
`endif
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_upd_valid", bus.update_valid_o, 0);
        check("rst_ctx", bus.predict_ctx_o, 0);
        @(negedge clk);
        check("rst_upd_pc", bus.update_pc_o, 0);
        check_perf();
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the
    // model across the edge, then check registered outputs.
    task automatic step(input bit av, input logic [31:0] apc,
                        input logic [31:0] atgt, input bit rv, input int rid,
                        input logic [31:0] rtgt, input bit rmis, input bit fl);
        bit rdy;
        bit drn;
        int p;
        int ns;
        bus.alloc_valid_i     = av;
        bus.alloc_pc_i        = apc;
        bus.alloc_target_i    = atgt;
        bus.resolve_valid_i   = rv;
        bus.resolve_id_i      = ID_W'(rid);
        bus.resolve_target_i  = rtgt;
        bus.resolve_mispred_i = rmis;
        bus.flush_i           = fl;
        #1;
        rdy = (q.size() < DEPTH) && !fl && !(rv && rmis);
        check("alloc_ready", bus.alloc_ready_o, rdy);
        check("alloc_id", bus.alloc_id_o, tail_id);
        drn = (q.size() > 0) && q[0].done;
        if (drn) begin
            e_uv   = 1'b1;
            e_upc  = q[0].pc;
            e_uctx = q[0].ctx;
            e_utgt = q[0].tgt;
            e_pupd++;
        end else begin
            e_uv = 1'b0;
        end
        p = -1;
        if (rv) foreach (q[i]) if (q[i].id == rid) p = i;
        if (p >= 0 && rmis) e_pmis++;
        if (fl) begin
            ns = 0;
            while (ns < q.size() && q[ns].done) ns++;
            if (ns > 0) hist = shl(q[ns-1].ctx, q[ns-1].tgt);
            if (q.size() > 0) tail_id = (q[0].id + ns) % DEPTH;
            while (q.size() > ns) void'(q.pop_back());
        end else begin
            if (p >= 0) begin
                q[p].done = 1'b1;
                q[p].tgt  = rtgt;
                if (rmis) begin
                    hist    = shl(q[p].ctx, rtgt);
                    tail_id = (q[p].id + 1) % DEPTH;
                    while (q.size() > p + 1) void'(q.pop_back());
                end
            end
            if (av && rdy) begin
                q.push_back('{tail_id, apc, hist, 1'b0, 32'h0});
                hist    = shl(hist, atgt);
                tail_id = (tail_id + 1) % DEPTH;
            end
        end
        if (drn) void'(q.pop_front());
        @(posedge clk);
        #1;
        check("upd_valid", bus.update_valid_o, e_uv);
        check("upd_pc", bus.update_pc_o, e_upc);
        check("upd_ctx", bus.update_ctx_o, e_uctx);
        check("upd_target", bus.update_target_o, e_utgt);
        check("predict_ctx", bus.predict_ctx_o, hist);
        check_perf();
        @(negedge clk);
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt);
        step(1, pc, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int id, input logic [31:0] tgt, input bit mis);
        step(0, 0, 0, 1, id, tgt, mis, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive_idle();
        do_reset();

        // First alloc from reset.
        alloc(32'h100, 32'h208);
        check("t1_ctx", bus.predict_ctx_o, 16'h0002);
        resolve(0, 32'h208, 0);
        idle();
        check("t1_drain_valid", bus.update_valid_o, 1);
        check("t1_drain_ctx", bus.update_ctx_o, 16'h0000);

        // Out-of-order resolves drain in order.
        do_reset();
        alloc(32'h200, 32'h204);
        alloc(32'h210, 32'h208);
        alloc(32'h220, 32'h20C);
        resolve(2, 32'h400, 0);
        resolve(0, 32'h404, 0);
        check("t2_no_early", bus.update_valid_o, 0);
        resolve(1, 32'h408, 0);
        check("t2_first_pc", bus.update_pc_o, 32'h200);
        idle();
        check("t2_second_pc", bus.update_pc_o, 32'h210);
        idle();
        check("t2_third_pc", bus.update_pc_o, 32'h220);

        // Fill to capacity.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(i * 4), 32'h200);
        alloc(32'h2000, 32'h204);
        check("t3_full_ready", bus.alloc_ready_o, 0);
        resolve(0, 32'h300, 0);
        idle();
        check("t3_ready_after_drain", bus.alloc_ready_o, 1);

        // Mispredict rewinds tail and history.
        do_reset();
        alloc(32'h100, 32'h208);
        alloc(32'h104, 32'h204);
        alloc(32'h108, 32'h200);
        alloc(32'h10C, 32'h20C);
        resolve(1, 32'h30C, 1);
        check("t4_hist", bus.predict_ctx_o, 16'h000B);
        check("t4_next_id", bus.alloc_id_o, 2);
        alloc(32'h110, 32'h204);

        // Alloc colliding with a mispredict is refused.
        step(1, 32'h500, 32'h504, 1, 0, 32'h208, 1, 0);
        check("t5_no_write", bus.alloc_id_o, 1);

        // Flush keeps only the resolved run at head.
        do_reset();
        alloc(32'h100, 32'h208);
        alloc(32'h104, 32'h20C);
        alloc(32'h108, 32'h200);
        alloc(32'h10C, 32'h204);
        resolve(2, 32'h208, 0);
        resolve(0, 32'h204, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_hist", bus.predict_ctx_o, 16'h0001);
        check("t6_tail", bus.alloc_id_o, 1);
        check("t6_drain", bus.update_valid_o, 1);

        // Perf counting: 5 updates, 2 mispredicts.
        do_reset();
        alloc(32'h100, 32'h200);
        alloc(32'h104, 32'h204);
        resolve(0, 32'h208, 1);
        alloc(32'h108, 32'h200);
        resolve(1, 32'h20C, 1);
        for (int i = 0; i < 3; i++) alloc(32'h200 + 32'(i * 4), 32'h204);
        for (int i = 2; i < 5; i++) resolve(i, 32'h300, 0);
        idle();
        idle();
        idle();
`ifdef ITTAGE_UPDQ_PERF_EN
        check("t7_perf_upd", bus.perf_update_o, 5);
        check("t7_perf_mis", bus.perf_mispred_o, 2);
`else
        check("t7_perf_upd", bus.perf_update_o, 0);
        check("t7_perf_mis", bus.perf_mispred_o, 0);
`endif

        // Asynchronous reset with a drain pending.
        do_reset();
        alloc(32'h100, 32'h20C);
        resolve(0, 32'h200, 0);
        rst = 1'b1;
        #1;
        check("t8_async_ctx", bus.predict_ctx_o, 0);
        check("t8_async_valid", bus.update_valid_o, 0);
        @(posedge clk);
        #1;
        check("t8_no_pulse", bus.update_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            bit av;
            bit rv;
            bit rm;
            bit fl;
            int rid;
            av = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 45);
            rm = ($urandom_range(0, 99) < 12);
            fl = ($urandom_range(0, 99) < 3);
            if (q.size() > 0 && $urandom_range(0, 9) != 0)
                rid = q[$urandom_range(0, q.size() - 1)].id;
            else
                rid = $urandom_range(0, DEPTH - 1);
            step(av, $urandom, $urandom, rv, rid, $urandom, rm, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
